// File: rtl/star_field_ctrl_pkg.sv
// Shared types and constants for the star field controller.
// Holds the per-star state encoding, screen geometry and the frame-counter width helper.
package star_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        BLINK  = 2'd2
    } star_state_t;

    localparam int unsigned SCREEN_W = 576;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 11;
    localparam int unsigned COUNT_W  = 4;

    // Counter must hold the largest phase length; keep at least 3 bits so bit 2 exists for blinking.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = int'($clog2(m + 1));
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/star_field_ctrl_if.sv
// Bundle of frame timing, random inputs, collision inputs and per-star outputs.
// The game-side driver uses master, the controller uses slave.
interface star_field_ctrl_if #(
    parameter int unsigned N_STARS = 4
);
    import star_pkg::*;

    logic                       startOfFrame;
    logic                       enable;
    logic [COORD_W-1:0]         randomX;
    logic [COORD_W-1:0]         randomY;
    logic [N_STARS-1:0]         collision;
    logic signed [COORD_W-1:0]  topLeftX [N_STARS];
    logic signed [COORD_W-1:0]  topLeftY [N_STARS];
    logic [N_STARS-1:0]         visible;
    logic [N_STARS-1:0]         collectPulse;
    logic [COUNT_W-1:0]         activeCount;

    modport master (
        output startOfFrame, enable, randomX, randomY, collision,
        input  topLeftX, topLeftY, visible, collectPulse, activeCount
    );

    modport slave (
        input  startOfFrame, enable, randomX, randomY, collision,
        output topLeftX, topLeftY, visible, collectPulse, activeCount
    );

endinterface

// File: rtl/star_slot.sv
// One star: EMPTY/ACTIVE/BLINK state machine, shared frame counter and latched position.
// ready_c flags that this slot may take the next spawn.
module star_slot
    import star_pkg::*;
#(
    parameter int unsigned LIFETIME_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES    = 16,
    parameter int unsigned RESPAWN_FRAMES  = 60,
    parameter int unsigned INITIAL_X       = 392,
    parameter int unsigned INITIAL_Y       = 228
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      enable,
    input  logic                      spawn,
    input  logic                      collision,
    input  logic [COORD_W-1:0]        spawnX,
    input  logic [COORD_W-1:0]        spawnY,
    output star_state_t               state,
    output logic                      ready_c,
    output logic                      visible,
    output logic                      collectPulse,
    output logic signed [COORD_W-1:0] topLeftX,
    output logic signed [COORD_W-1:0] topLeftY
);

    localparam int unsigned CW = cnt_width(LIFETIME_FRAMES, BLINK_FRAMES, RESPAWN_FRAMES);

    star_state_t               state_d;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_d;
    logic [CW-1:0]             cnt_dec;
    logic                      last_frame;
    logic                      visible_d;
    logic                      pulse_d;
    logic signed [COORD_W-1:0] x_d;
    logic signed [COORD_W-1:0] y_d;

    assign ready_c    = (state == EMPTY) && (cnt == '0);
    assign cnt_dec    = (cnt == '0) ? '0 : cnt - CW'(1);
    assign last_frame = (cnt <= CW'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= EMPTY;
            cnt          <= '0;
            topLeftX     <= COORD_W'(INITIAL_X);
            topLeftY     <= COORD_W'(INITIAL_Y);
            visible      <= 1'b0;
            collectPulse <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            topLeftX     <= x_d;
            topLeftY     <= y_d;
            visible      <= visible_d;
            collectPulse <= pulse_d;
        end
    end

    // Collision in ACTIVE takes priority over a same-cycle lifetime expiry.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        x_d     = topLeftX;
        y_d     = topLeftY;
        pulse_d = 1'b0;
        if (enable) begin
            unique case (state)
                EMPTY: begin
                    if (spawn) begin
                        state_d = ACTIVE;
                        cnt_d   = CW'(LIFETIME_FRAMES);
                        x_d     = $signed(spawnX);
                        y_d     = $signed(spawnY);
                    end else if (startOfFrame) begin
                        cnt_d = cnt_dec;
                    end
                end
                ACTIVE: begin
                    if (collision) begin
                        state_d = BLINK;
                        cnt_d   = CW'(BLINK_FRAMES);
                        pulse_d = 1'b1;
                    end else if (startOfFrame) begin
                        if (last_frame) begin
                            state_d = EMPTY;
                            cnt_d   = CW'(RESPAWN_FRAMES);
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                end
                BLINK: begin
                    if (startOfFrame) begin
                        if (last_frame) begin
                            state_d = EMPTY;
                            cnt_d   = CW'(RESPAWN_FRAMES);
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
        visible_d = (state_d == ACTIVE) || ((state_d == BLINK) && cnt_d[2]);
    end

endmodule

// File: rtl/star_field_ctrl.sv
// Multi-star controller: clamps random spawn positions, grants one spawn per frame to the
// lowest-index free slot and reports how many stars are currently collectible.
module star_field_ctrl
    import star_pkg::*;
#(
    parameter int unsigned N_STARS         = 4,
    parameter int unsigned OBJ_SIZE        = 32,
    parameter int unsigned X_MAX           = SCREEN_W - OBJ_SIZE - 1,
    parameter int unsigned Y_MAX           = SCREEN_H - OBJ_SIZE - 1,
    parameter int unsigned INITIAL_X       = 392,
    parameter int unsigned INITIAL_Y       = 228,
    parameter int unsigned LIFETIME_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES    = 16,
    parameter int unsigned RESPAWN_FRAMES  = 60
) (
    input logic              clk,
    input logic              resetN,
    star_field_ctrl_if.slave bus
);

    logic [COORD_W-1:0]        clamp_x_c;
    logic [COORD_W-1:0]        clamp_y_c;
    logic [N_STARS-1:0]        ready_c;
    logic [N_STARS-1:0]        spawn_c;
    logic [N_STARS-1:0]        active_c;
    logic [N_STARS-1:0]        vis;
    logic [N_STARS-1:0]        pulse;
    logic signed [COORD_W-1:0] pos_x [N_STARS];
    logic signed [COORD_W-1:0] pos_y [N_STARS];
    star_state_t               state [N_STARS];
    logic [COUNT_W-1:0]        active_cnt;
    logic [COUNT_W-1:0]        active_cnt_c;

    assign clamp_x_c = (bus.randomX > COORD_W'(X_MAX)) ? COORD_W'(X_MAX) : bus.randomX;
    assign clamp_y_c = (bus.randomY > COORD_W'(Y_MAX)) ? COORD_W'(Y_MAX) : bus.randomY;

    // Isolate the lowest set ready bit so at most one slot spawns per frame.
    assign spawn_c = {N_STARS{bus.startOfFrame & bus.enable}} & ready_c & (~ready_c + 1'b1);

    for (genvar g = 0; g < N_STARS; g++) begin : g_slot
        star_slot #(
            .LIFETIME_FRAMES (LIFETIME_FRAMES),
            .BLINK_FRAMES    (BLINK_FRAMES),
            .RESPAWN_FRAMES  (RESPAWN_FRAMES),
            .INITIAL_X       (INITIAL_X),
            .INITIAL_Y       (INITIAL_Y)
        ) u_slot (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (bus.startOfFrame),
            .enable       (bus.enable),
            .spawn        (spawn_c[g]),
            .collision    (bus.collision[g]),
            .spawnX       (clamp_x_c),
            .spawnY       (clamp_y_c),
            .state        (state[g]),
            .ready_c      (ready_c[g]),
            .visible      (vis[g]),
            .collectPulse (pulse[g]),
            .topLeftX     (pos_x[g]),
            .topLeftY     (pos_y[g])
        );
        assign active_c[g] = (state[g] == ACTIVE);
    end

    always_comb begin
        active_cnt_c = '0;
        for (int i = 0; i < N_STARS; i++) begin
            active_cnt_c = active_cnt_c + COUNT_W'(active_c[i]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) active_cnt <= '0;
        else         active_cnt <= active_cnt_c;
    end

    assign bus.topLeftX     = pos_x;
    assign bus.topLeftY     = pos_y;
    assign bus.visible      = vis;
    assign bus.collectPulse = pulse;
    assign bus.activeCount  = active_cnt;

endmodule

// File: tb/tb_star_field_ctrl.sv
// Directed bench for star_field_ctrl: spawn order, clamping, collection, expiry,
// collision/expiry race and enable freeze, each scenario starting from a fresh reset.
module tb_star_field_ctrl;
    import star_pkg::*;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic resetN;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulse_total [N] = '{default: 0};

    star_field_ctrl_if #(.N_STARS(N)) bus ();

    star_field_ctrl #(.N_STARS(N)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Mid-cycle pulse counter per star.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.collectPulse[i]) pulse_total[i] = pulse_total[i] + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic do_reset();
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.enable       = 1'b1;
        bus.collision    = '0;
        bus.randomX      = 11'd100;
        bus.randomY      = 11'd50;
        repeat (2) @(posedge clk);
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic frame();
        @(posedge clk); #1 bus.startOfFrame = 1'b1;
        @(posedge clk); #1 bus.startOfFrame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (bus.topLeftX[i] !== 11'sd392 || bus.topLeftY[i] !== 11'sd228) begin
                miscompares++;
                $display("FAIL reset_pos[%0d]: got (%0d,%0d) expected (392,228)", i,
                         bus.topLeftX[i], bus.topLeftY[i]);
            end
        end
        vectors++;
        if (bus.visible !== 4'b0000 || bus.collectPulse !== 4'b0000 || bus.activeCount !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: vis=%b pulse=%b cnt=%0d expected 0000 0000 0",
                     bus.visible, bus.collectPulse, bus.activeCount);
        end
        frames(2);
        vectors++;
        if (bus.activeCount !== 4'd2) begin
            miscompares++;
            $display("FAIL pre_async_count: got %0d expected 2", bus.activeCount);
        end
        @(posedge clk); #3 resetN = 1'b0;
        #1;
        vectors++;
        if (bus.visible !== 4'b0000 || bus.activeCount !== 4'd0 || bus.topLeftX[0] !== 11'sd392) begin
            miscompares++;
            $display("FAIL async_reset: vis=%b cnt=%0d x0=%0d expected 0000 0 392",
                     bus.visible, bus.activeCount, bus.topLeftX[0]);
        end
        @(negedge clk) resetN = 1'b1;
    endtask

    task automatic test_spawn_order();
        logic [3:0] exp_vis [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        do_reset();
        // First frame by hand to check the one-clock latencies.
        @(posedge clk); #1 bus.startOfFrame = 1'b1;
        @(posedge clk); #1 bus.startOfFrame = 1'b0;
        vectors++;
        if (bus.visible[0] !== 1'b1 || bus.activeCount !== 4'd0) begin
            miscompares++;
            $display("FAIL spawn_latency: vis0=%b cnt=%0d expected 1 0", bus.visible[0], bus.activeCount);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.activeCount !== 4'd1) begin
            miscompares++;
            $display("FAIL count_latency: got %0d expected 1", bus.activeCount);
        end
        vectors++;
        if (bus.topLeftX[1] !== 11'sd392) begin
            miscompares++;
            $display("FAIL unspawned_pos: x1=%0d expected 392", bus.topLeftX[1]);
        end
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) frame();
            vectors++;
            if (bus.visible !== exp_vis[k-1] || bus.activeCount !== 4'(k) ||
                bus.topLeftX[k-1] !== 11'sd100 || bus.topLeftY[k-1] !== 11'sd50) begin
                miscompares++;
                $display("FAIL spawn_order[%0d]: vis=%b cnt=%0d pos=(%0d,%0d) expected %b %0d (100,50)",
                         k, bus.visible, bus.activeCount, bus.topLeftX[k-1], bus.topLeftY[k-1],
                         exp_vis[k-1], k);
            end
        end
    endtask

    task automatic test_clamp();
        logic [10:0] rx [4] = '{11'd700, 11'd543, 11'd542, 11'd2047};
        logic [10:0] ry [4] = '{11'd600, 11'd448, 11'd446, 11'd2047};
        int          ex [4] = '{543, 543, 542, 543};
        int          ey [4] = '{447, 447, 446, 447};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.randomX = rx[k];
            bus.randomY = ry[k];
            frame();
            vectors++;
            if (int'(bus.topLeftX[k]) != ex[k] || int'(bus.topLeftY[k]) != ey[k]) begin
                miscompares++;
                $display("FAIL clamp[%0d]: got (%0d,%0d) expected (%0d,%0d)", k,
                         bus.topLeftX[k], bus.topLeftY[k], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_collect();
        logic [15:0] blink_exp = 16'b1111_0000_1111_0000;
        int p0, p1;
        do_reset();
        frames(2);
        bus.randomX = 11'd200;
        bus.randomY = 11'd300;
        p0 = pulse_total[0];
        p1 = pulse_total[1];
        bus.collision = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin
                vectors++;
                if (bus.collectPulse[1] !== (i == 0)) begin
                    miscompares++;
                    $display("FAIL collect_pulse_cycle%0d: got %b expected %b", i,
                             bus.collectPulse[1], (i == 0));
                end
            end
        end
        bus.collision = '0;
        @(posedge clk); #1;
        vectors++;
        if (pulse_total[1] - p1 != 1 || pulse_total[0] != p0) begin
            miscompares++;
            $display("FAIL collect_pulse_count: star1=%0d star0=%0d expected 1 0",
                     pulse_total[1] - p1, pulse_total[0] - p0);
        end
        vectors++;
        if (bus.visible[1] !== 1'b0 || bus.activeCount !== 4'd1) begin
            miscompares++;
            $display("FAIL collect_blink_start: vis1=%b cnt=%0d expected 0 1", bus.visible[1], bus.activeCount);
        end
        for (int f = 1; f <= 16; f++) begin
            frame();
            vectors++;
            if (bus.visible[1] !== blink_exp[16-f]) begin
                miscompares++;
                $display("FAIL blink_frame%0d: vis1=%b expected %b", f, bus.visible[1], blink_exp[16-f]);
            end
        end
        vectors++;
        if (bus.topLeftX[1] !== 11'sd100 || bus.activeCount !== 4'd3) begin
            miscompares++;
            $display("FAIL blink_end: x1=%0d cnt=%0d expected 100 3", bus.topLeftX[1], bus.activeCount);
        end
        for (int f = 1; f <= 60; f++) begin
            frame();
            vectors++;
            if (bus.visible[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL respawn_wait%0d: vis1=%b expected 0", f, bus.visible[1]);
            end
        end
        frame();
        vectors++;
        if (bus.visible[1] !== 1'b1 || bus.topLeftX[1] !== 11'sd200 || bus.topLeftY[1] !== 11'sd300 ||
            bus.activeCount !== 4'd4) begin
            miscompares++;
            $display("FAIL respawn: vis1=%b pos=(%0d,%0d) cnt=%0d expected 1 (200,300) 4",
                     bus.visible[1], bus.topLeftX[1], bus.topLeftY[1], bus.activeCount);
        end
    endtask

    task automatic test_expiry();
        int p0;
        do_reset();
        p0 = pulse_total[0];
        frames(180);
        vectors++;
        if (bus.visible[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL expiry_last_frame: vis0=%b expected 1", bus.visible[0]);
        end
        frame();
        vectors++;
        if (bus.visible[0] !== 1'b0 || bus.activeCount !== 4'd3) begin
            miscompares++;
            $display("FAIL expiry: vis0=%b cnt=%0d expected 0 3", bus.visible[0], bus.activeCount);
        end
        frames(60);
        vectors++;
        if (bus.visible[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL expiry_wait: vis0=%b expected 0", bus.visible[0]);
        end
        frame();
        vectors++;
        if (bus.visible[0] !== 1'b1 || pulse_total[0] != p0) begin
            miscompares++;
            $display("FAIL expiry_respawn: vis0=%b pulses=%0d expected 1 0", bus.visible[0],
                     pulse_total[0] - p0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        frames(180);
        @(posedge clk); #1;
        bus.startOfFrame = 1'b1;
        bus.collision    = 4'b0001;
        @(posedge clk); #1;
        bus.startOfFrame = 1'b0;
        bus.collision    = '0;
        vectors++;
        if (bus.collectPulse[0] !== 1'b1 || bus.visible[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_pulse: pulse0=%b vis0=%b expected 1 0", bus.collectPulse[0], bus.visible[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.activeCount !== 4'd3) begin
            miscompares++;
            $display("FAIL simul_count: got %0d expected 3", bus.activeCount);
        end
        frame();
        vectors++;
        if (bus.visible[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_blink: vis0=%b expected 1", bus.visible[0]);
        end
    endtask

    task automatic test_freeze();
        int p0;
        do_reset();
        bus.enable = 1'b0;
        frame();
        vectors++;
        if (bus.visible !== 4'b0000 || bus.activeCount !== 4'd0) begin
            miscompares++;
            $display("FAIL freeze_no_spawn: vis=%b cnt=%0d expected 0000 0", bus.visible, bus.activeCount);
        end
        bus.enable = 1'b1;
        frames(100);
        p0 = pulse_total[0];
        bus.enable    = 1'b0;
        bus.collision = 4'b0001;
        frames(50);
        bus.collision = '0;
        @(posedge clk); #1;
        vectors++;
        if (bus.visible !== 4'b1111 || bus.activeCount !== 4'd4 || pulse_total[0] != p0 ||
            bus.topLeftX[0] !== 11'sd100) begin
            miscompares++;
            $display("FAIL freeze_hold: vis=%b cnt=%0d pulses=%0d x0=%0d expected 1111 4 0 100",
                     bus.visible, bus.activeCount, pulse_total[0] - p0, bus.topLeftX[0]);
        end
        bus.enable = 1'b1;
        frames(80);
        vectors++;
        if (bus.visible[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_delay: vis0=%b expected 1", bus.visible[0]);
        end
        frame();
        vectors++;
        if (bus.visible[0] !== 1'b0 || pulse_total[0] != p0) begin
            miscompares++;
            $display("FAIL freeze_expiry: vis0=%b pulses=%0d expected 0 0", bus.visible[0],
                     pulse_total[0] - p0);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_order();
        test_clamp();
        test_collect();
        test_expiry();
        test_simultaneous();
        test_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/star_field_ctrl.md
# star_field_ctrl

Parametrised multi-star controller for the VGA game layer. It holds N_STARS independent collectible stars and spawns each at a random on-screen position taken from the shared random generators. Each star has a finite lifetime, a blink-out phase after being collected, and a respawn delay. It sits between the random-number generators, the per-star draw/collision logic and the score logic.

## Interface
- N_STARS, 4: number of star channels (1..8)
- OBJ_SIZE, 32: star bitmap edge in pixels
- X_MAX, 543: largest legal topLeftX (576 − OBJ_SIZE − 1)
- Y_MAX, 447: largest legal topLeftY (480 − OBJ_SIZE − 1)
- INITIAL_X, 392 / INITIAL_Y, 228: reset position of every star
- LIFETIME_FRAMES, 180: frames a star stays ACTIVE if not collected
- BLINK_FRAMES, 16: frames in the BLINK phase
- RESPAWN_FRAMES, 60: frames spent EMPTY before a star is eligible to spawn

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- enable  in  1  game running; low freezes all state
- randomX  in  11  unsigned random X
- randomY  in  11  unsigned random Y
- collision  in  N_STARS  per-star hit from draw logic, level, any cycle
- topLeftX  out  N_STARS×11 signed  per-star top-left X
- topLeftY  out  N_STARS×11 signed  per-star top-left Y
- visible  out  N_STARS  per-star draw enable
- collectPulse  out  N_STARS  one-cycle pulse when a star is collected
- activeCount  out  4  number of stars in ACTIVE

## Operation
- Per-star FSM with states EMPTY, ACTIVE and BLINK. Each star has one frame counter, wide enough for max(LIFETIME, BLINK, RESPAWN).
- Reset (async): all stars EMPTY with counter 0, topLeftX=INITIAL_X, topLeftY=INITIAL_Y, visible=0, collectPulse=0, activeCount=0.
- Counters decrement by 1 on startOfFrame when enable=1, saturating at 0.
- Spawn:
  - On startOfFrame with enable=1, the lowest-index star that is EMPTY with counter 0 spawns. At most one spawn per frame.
  - The spawning star latches X = min(randomX, X_MAX) and Y = min(randomY, Y_MAX). It goes ACTIVE with counter = LIFETIME_FRAMES.
  - Positions are integer pixels and change only at spawn.
- ACTIVE:
  - visible=1.
  - collision[i]=1 with enable=1 moves the star to BLINK on the next clock edge, with counter = BLINK_FRAMES. collectPulse[i]=1 for exactly that one cycle.
  - Lifetime expiry: on startOfFrame, if the counter would reach 0, the star goes EMPTY with counter = RESPAWN_FRAMES. No collectPulse.
- BLINK:
  - visible = counter[2]: toggles every 4 frames.
  - Collisions are ignored.
  - When the counter reaches 0 on startOfFrame, the star goes EMPTY with counter = RESPAWN_FRAMES.
- EMPTY: visible=0. Collisions are ignored.
- Simultaneous events:
  - Collision in the same cycle as lifetime expiry: collision wins (BLINK + pulse).
  - A star expiring or finishing BLINK on a startOfFrame cannot spawn on that same frame.
- enable=0: no counting, no spawning, collisions ignored. Outputs hold their values.
- activeCount is the registered popcount of stars in ACTIVE.

## Timing
- All outputs are registered. Latency from startOfFrame to new topLeftX/Y, visible and state is 1 clock.
- Latency from collision to collectPulse and visible change is 1 clock. A collision held for many cycles produces a single pulse.
- Reset mid-frame takes effect immediately (async). After release, the first startOfFrame spawns star 0, the next spawns star 1, and so on.
- activeCount updates 1 clock after the state change that alters it.

## Structure
- Package star_pkg:
  - star_state_t enum (EMPTY, ACTIVE, BLINK).
  - Screen constants 576/480.
  - Frame-counter width function.
- Sub-module star_slot: one star's FSM, counter and position registers. It takes a spawn strobe plus the clamped X/Y and outputs state, visible, collectPulse and position.
- The top level generates N_STARS slots and contains:
  - the clamp logic,
  - the lowest-index priority spawn arbiter,
  - the activeCount popcount.

## Test plan
- Reset release, enable=1, randomX=100, randomY=50, 4 frames → star k is ACTIVE at (100,50) after frame k; activeCount goes 1, 2, 3, 4.
- randomX=700, randomY=600 at spawn → star position is (543,447).
- Star 1 ACTIVE, collision[1] high for 10 cycles → collectPulse[1] is high for exactly 1 cycle. visible[1] blinks for 16 frames, then is 0 for 60 frames, then star 1 respawns.
- No collisions for 180 frames → star goes EMPTY, collectPulse stays 0, and it respawns 60 frames later.
- Collision in the same cycle as the expiry frame pulse → state BLINK and collectPulse=1.
- enable=0 for 50 frames mid-lifetime, then enable=1 → expiry is delayed by exactly 50 frames, and collisions during the freeze give no pulse.
